// File: rtl/fifo_umbrales_if.sv
// Handshake and status bundle between the threshold FIFO and its flow-control master.
interface fifo_umbrales_if #(
  parameter int unsigned DATA_WIDTH   = 6,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned UMBRALES_L_H = 8
);
  logic [UMBRALES_L_H-1:0] umbral_LH;
  logic                    push;
  logic [DATA_WIDTH-1:0]   data_in;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    valid_out;
  logic                    empty;
  logic                    full;
  logic                    almost_empty;
  logic                    almost_full;
  logic                    error;
  logic [ADDR_WIDTH:0]     count;

  modport master (
    output umbral_LH, push, data_in, pop,
    input  data_out, valid_out, empty, full, almost_empty, almost_full, error, count
  );

  modport slave (
    input  umbral_LH, push, data_in, pop,
    output data_out, valid_out, empty, full, almost_empty, almost_full, error, count
  );
endinterface

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with programmable low/high occupancy thresholds and sticky
// overflow/underflow error; storage end of the flow-control loop.
module fifo_umbrales #(
  parameter int unsigned DATA_WIDTH   = 6,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned UMBRALES_L_H = 8
) (
  input  logic              clk,
  input  logic              reset,
  fifo_umbrales_if.slave    bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned TH_W  = UMBRALES_L_H / 2;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;
  logic [UMBRALES_L_H-1:0] umbral_q, umbral_d;

  logic [PTR_W-1:0]        count_c;
  logic [TH_W-1:0]         umbral_h_c;
  logic [TH_W-1:0]         umbral_l_c;
  logic                    empty_c;
  logic                    full_c;
  logic                    do_push_c;
  logic                    do_pop_c;

  // Occupancy from wrap-bit pointers; flags are combinational on registered thresholds
  always_comb begin
    count_c    = wr_ptr_q - rd_ptr_q;
    umbral_h_c = umbral_q[UMBRALES_L_H-1 -: TH_W];
    umbral_l_c = umbral_q[TH_W-1:0];
    empty_c    = (count_c == '0);
    full_c     = (count_c == PTR_W'(DEPTH));
    do_push_c  = bus.push && !full_c;
    do_pop_c   = bus.pop && !empty_c;
  end

  // Next-state for pointers, read port, error and threshold register
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    error_d    = error_q;
    umbral_d   = bus.umbral_LH;

    if (do_push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (do_pop_c) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      data_out_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      valid_d    = 1'b1;
    end

    if ((bus.push && full_c) || (bus.pop && empty_c)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      umbral_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      umbral_q   <= umbral_d;
    end
  end

  // Storage array carries no reset; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.error        = error_q;
  assign bus.count        = count_c;
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.almost_empty = (count_c <= PTR_W'(umbral_l_c));
  // Held low while in reset so the reset-state flag reads 0 even though H clears to 0
  assign bus.almost_full  = reset && (count_c >= PTR_W'(umbral_h_c));

endmodule
